// File: rtl/uart_pkg.sv
// Shared definitions for the stack-draining UART transmitter.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // 12 MHz ICEstick clock at 115200 baud.
    localparam int unsigned DEFAULT_BAUD_DIV = 104;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StStart = START,
        StData  = DATA,
        StStop  = STOP
    } tx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running down-counter producing a one-cycle tick every BAUD_DIV cycles.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);

    localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(BAUD_DIV - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q - CntW'(1);
        if (load || (cnt_q == '0)) begin
            cnt_d = Reload;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the stack head once each and sends them as UART 8N1 frames.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EN,
    input  logic [DATA_WIDTH-1:0] FIFO_data,
    input  logic                  FIFO_empty,
    input  logic                  FIFO_busy,
    output logic                  FIFO_pop,
    output logic                  TX,
    output logic                  TX_busy
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

    tx_state_e             state_d, state_q;
    logic [DATA_WIDTH-1:0] shift_d, shift_q;
    logic [BitW-1:0]       bit_cnt_d, bit_cnt_q;
    logic                  pop_d, pop_q;
    logic                  tx_d, tx_q;
    logic                  busy_d, busy_q;
    logic                  start, load, tick;

    assign start = EN && !FIFO_empty && !FIFO_busy;
    assign load  = (state_q == StIdle) && start;

    baud_tick_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pop_d     = 1'b0;
        tx_d      = tx_q;
        busy_d    = busy_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStart;
                    shift_d = FIFO_data;
                    pop_d   = 1'b1;
                    tx_d    = ~UART_IDLE_LEVEL;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d   = StData;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    // The bit on the line when the counter hits LastBit is the final one.
                    if (bit_cnt_q == LastBit) begin
                        tx_d    = UART_IDLE_LEVEL;
                        state_d = StStop;
                    end else begin
                        tx_d = shift_q[0];
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            pop_q     <= 1'b0;
            tx_q      <= UART_IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            pop_q     <= pop_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign FIFO_pop = pop_q;
    assign TX       = tx_q;
    assign TX_busy  = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench: a UART line decoder checks every frame against bytes queued in the stack.
module tb_fifo_uart_tx;

    localparam int B = 4;
    localparam int W = 8;
    localparam int FrameCycles = (W + 2) * B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       EN = 1'b0;
    logic       FIFO_busy = 1'b0;
    logic [7:0] FIFO_data;
    logic       FIFO_empty;
    logic       FIFO_pop;
    logic       TX;
    logic       TX_busy;

    logic [7:0]  mem [0:255];
    int unsigned rd = 0;
    int unsigned wr = 0;
    int unsigned cyc = 0;

    logic [7:0]  exp_q [$];
    int unsigned pop_cyc [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          n_frames = 0;
    bit          cond_last = 1'b0;

    assign FIFO_empty = (rd == wr);
    assign FIFO_data  = mem[rd[7:0]];

    fifo_uart_tx #(
        .DATA_WIDTH(W),
        .BAUD_DIV  (B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EN        (EN),
        .FIFO_data (FIFO_data),
        .FIFO_empty(FIFO_empty),
        .FIFO_busy (FIFO_busy),
        .FIFO_pop  (FIFO_pop),
        .TX        (TX),
        .TX_busy   (TX_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stack: a pop seen at an edge retires the head row.
    always @(posedge clk) begin
        if (FIFO_pop === 1'b1 && rd != wr) rd <= rd + 1;
    end

    task automatic chk(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr[7:0]] = b;
        wr = wr + 1;
        exp_q.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(FIFO_empty && TX_busy === 1'b0) && n < 3000);
        chk(name, n < 3000, n, 3000);
        repeat (3) step();
    endtask

    task automatic wait_pop(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (FIFO_pop !== 1'b1 && n < 200);
        chk(name, n < 200, n, 200);
    endtask

    // Decodes one frame starting at the current negedge (first cycle of the start bit).
    task automatic check_frame();
        logic [7:0] e;
        logic [9:0] bits;
        logic [9:0] rx;
        bit tx_ok = 1'b1;
        bit busy_ok = 1'b1;
        bit pop_ok = 1'b1;
        bit aborted = 1'b0;
        n_frames++;
        chk("frame_expected", exp_q.size() != 0, 1, 0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        bits = {1'b1, e, 1'b0};
        rx = '0;
        for (int c = 0; c < FrameCycles; c++) begin
            if (c > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
                aborted = 1'b1;
                break;
            end
            if (TX !== bits[c / B]) tx_ok = 1'b0;
            if (c % B == B / 2) rx[c / B] = TX;
            if (TX_busy !== 1'b1) busy_ok = 1'b0;
            if (FIFO_pop !== (c == 0)) pop_ok = 1'b0;
        end
        if (!aborted) begin
            chk("frame_bits", tx_ok && rx == bits, {22'd0, rx}, {22'd0, bits});
            chk("frame_busy", busy_ok, busy_ok, 1);
            chk("frame_pop_once", pop_ok, pop_ok, 1);
            @(negedge clk);
            chk("frame_gap_idle", TX === 1'b1 && TX_busy === 1'b0, {TX, TX_busy}, 2'b10);
        end
    endtask

    initial begin : line_monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && TX === 1'b0) check_frame();
        end
    end

    // A pop must appear exactly at the edge after an idle cycle with the start condition true.
    initial begin : pop_monitor
        forever begin
            @(negedge clk);
            if (FIFO_pop === 1'b1) begin
                pop_cyc.push_back(cyc);
                n_pops++;
            end
            if (FIFO_pop === 1'b1 || cond_last) begin
                chk("pop_vs_start", FIFO_pop === cond_last, FIFO_pop, cond_last);
            end
            cond_last = (rst_n === 1'b1) && EN && !FIFO_empty && !FIFO_busy &&
                        (TX_busy === 1'b0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        int n0;
        int p0;

        // Reset held with a non-empty stack and EN high.
        EN = 1'b1;
        push(8'h11);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (TX !== 1'b1 || TX_busy !== 1'b0 || FIFO_pop !== 1'b0) ok = 1'b0;
        end
        chk("reset_outputs", ok, {TX, TX_busy, FIFO_pop}, 3'b100);
        chk("reset_no_pop", n_pops == 0 && rd == 0, n_pops, 0);
        step();
        rst_n = 1'b1;
        wait_idle("reset_release_idle");

        // Single byte.
        n0 = pop_cyc.size();
        push(8'hA5);
        wait_idle("single_idle");
        chk("single_one_pop", pop_cyc.size() == n0 + 1, pop_cyc.size() - n0, 1);

        // Back-to-back frames.
        n0 = pop_cyc.size();
        push(8'h00);
        push(8'hFF);
        wait_idle("b2b_idle");
        chk("b2b_two_pops", pop_cyc.size() == n0 + 2, pop_cyc.size() - n0, 2);
        if (pop_cyc.size() >= n0 + 2) begin
            chk("b2b_spacing", pop_cyc[n0 + 1] - pop_cyc[n0] == FrameCycles + 1,
                pop_cyc[n0 + 1] - pop_cyc[n0], FrameCycles + 1);
        end

        // Busy gating.
        FIFO_busy = 1'b1;
        push(8'h5A);
        p0 = n_pops;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (TX !== 1'b1) ok = 1'b0;
        end
        chk("busy_hold", ok && n_pops == p0, n_pops - p0, 0);
        step();
        FIFO_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_release_start", FIFO_pop === 1'b1 && TX === 1'b0, {FIFO_pop, TX}, 2'b10);
        wait_idle("busy_idle");

        // EN dropped mid-frame with more data queued.
        push(8'h3C);
        push(8'h77);
        wait_pop("en_drop_pop");
        repeat (15) step();
        EN = 1'b0;
        p0 = n_pops;
        n0 = 0;
        while (TX_busy !== 1'b0 && n0 < 200) begin
            @(negedge clk);
            n0++;
        end
        chk("en_drop_frame_end", n0 < 200, n0, 200);
        repeat (60) @(negedge clk);
        chk("en_drop_no_pop", n_pops == p0 && !FIFO_empty, n_pops - p0, 0);
        step();
        EN = 1'b1;
        wait_idle("en_resume_idle");

        // Reset 20 cycles into a frame.
        push(8'h96);
        wait_pop("abort_pop");
        repeat (20) step();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_outputs", TX === 1'b1 && TX_busy === 1'b0 && FIFO_pop === 1'b0,
            {TX, TX_busy, FIFO_pop}, 3'b100);
        step();
        rst_n = 1'b1;
        push(8'hC3);
        wait_idle("abort_recover_idle");

        // Randomised traffic with busy and EN noise.
        for (int i = 0; i < 1500; i++) begin
            step();
            FIFO_busy = ($urandom_range(0, 3) == 0);
            EN = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) push(8'($urandom_range(0, 255)));
        end
        step();
        FIFO_busy = 1'b0;
        EN = 1'b1;
        wait_idle("random_idle");

        chk("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
        chk("pops_match_frames", n_pops == n_frames, n_pops, n_frames);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Consumer end of `fifo_stack` for the ICEstick USB3300 parser. It drains bytes from the stack's head, popping each one exactly once, and serialises them as UART 8N1 frames on a single TX line toward the host. It replaces ad-hoc pop logic in the top level with one clean read-side handshake against the stack's `FIFO_empty` and `FIFO_busy` flags.

## Interface
- `DATA_WIDTH`, default 8: frame payload bits; must match the stack's `STACK_WIDTH`.
- `BAUD_DIV`, default 104: clk cycles per bit (12 MHz / 115200); legal range 2..65535.
- `clk` in 1: master clock; single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `EN` in 1: start-of-frame permission; sampled only in IDLE.
- `FIFO_data` in DATA_WIDTH: stack `O_DATA`, the current head row.
- `FIFO_empty` in 1: stack empty flag.
- `FIFO_busy` in 1: stack busy flag; no pop may be issued while it is high.
- `FIFO_pop` out 1: one-cycle pop strobe to the stack.
- `TX` out 1: UART line; idles high.
- `TX_busy` out 1: high from frame start until the stop bit completes.

## Operation
- States are IDLE, START, DATA, and STOP.
- IDLE to START happens at an edge where `EN && !FIFO_empty && !FIFO_busy` holds. At that edge:
  - `FIFO_data` is latched into the shift register.
  - `FIFO_pop` is set to 1, `TX` to 0, and `TX_busy` to 1.
  - The baud counter loads `BAUD_DIV-1`.
- The baud counter decrements every cycle. At 0 it reloads `BAUD_DIV-1` and produces a bit tick.
- START: on the tick, go to DATA. Drive the shift register's LSB and clear the bit counter.
- DATA: on each tick, shift right and increment the bit counter. After `DATA_WIDTH` bits, drive `TX`=1 and go to STOP. Transmission is LSB first.
- STOP: on the tick, go to IDLE and clear `TX_busy`.
- `FIFO_pop` is high for exactly one cycle per frame and is never re-asserted within the frame.
- `FIFO_empty` and `FIFO_busy` are ignored outside IDLE.
- Dropping `EN` mid-frame does not abort the frame; the current frame completes and no new one starts.
- If `FIFO_empty` or `FIFO_busy` is high in IDLE, the block stays in IDLE with `TX`=1 and no pop issued.
- `EN` held high with 1 in `FIFO_data` from the `FIFO_empty` deassert: the frame starts on the first edge where `!FIFO_busy` holds.
- Reset mid-frame aborts the frame:
  - On the next edge `TX`=1, `TX_busy`=0, `FIFO_pop`=0, and the state returns to IDLE.
  - The popped byte is lost, which is accepted.
- Reset values: `TX`=1, `TX_busy`=0, `FIFO_pop`=0, state IDLE, all counters 0.
- Counter widths:
  - The baud counter is `$clog2(BAUD_DIV)` bits.
  - The bit counter is `$clog2(DATA_WIDTH+1)` bits.
  - Neither counter wraps except by explicit reload.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Start latency: with the start condition true at edge k, `TX` falls and `FIFO_pop` rises at edge k, i.e. both are visible in the cycle after k.
- `FIFO_pop` falls at edge k+1.
- Bit durations:
  - The start bit lasts `BAUD_DIV` cycles.
  - Each data bit lasts `BAUD_DIV` cycles.
  - The stop bit lasts `BAUD_DIV` cycles.
  - The whole frame is `(DATA_WIDTH+2)*BAUD_DIV` cycles.
- Back-to-back frames: IDLE occupies at least 1 cycle between frames, so the frame period is `(DATA_WIDTH+2)*BAUD_DIV+1` cycles.
- Head data must be valid at edge k. The stack presents the head combinationally, and the pop takes effect after edge k+1.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3);
  - `UART_IDLE_LEVEL`=1;
  - the default `BAUD_DIV` for the 12 MHz ICEstick clock.
- One sub-module, `baud_tick_gen`:
  - parameter `BAUD_DIV`; inputs `clk`, `rst_n`, `load`; output `tick`;
  - reload on `load`; `tick` is one cycle wide.
- Everything else lives in `fifo_uart_tx`.

## Test plan
All scenarios run with `BAUD_DIV`=4, `DATA_WIDTH`=8, driven by a behavioural stack model.
- Reset: hold `rst_n`=0 for 3 cycles with the stack non-empty. Required: `TX`=1, `TX_busy`=0, `FIFO_pop`=0 throughout, and no pop issued.
- Single byte 0xA5 with `EN`=1:
  - `FIFO_pop` is a single one-cycle pulse.
  - `TX` shows 0, then 1,0,1,0,0,1,0,1, then 1, each level lasting 4 cycles; frame length 40 cycles.
  - `TX_busy` is high for exactly 40 cycles.
- Back-to-back 0x00 then 0xFF:
  - Two pops, 41 cycles apart.
  - Correct bit patterns for both frames, with a 1-cycle idle-high gap between them.
- Busy gating:
  - Stack non-empty with `FIFO_busy` high for 10 cycles: required no pop and `TX` stays 1.
  - Start occurs at the first edge after `FIFO_busy` falls.
- `EN` dropped mid-frame (cycle 15 of byte 0x3C) with more data queued: required that 0x3C completes intact and no further pop occurs while `EN`=0.
- Reset at cycle 20 of a frame: required `TX`=1 and `TX_busy`=0 on the next edge, and a fresh frame starts cleanly once `rst_n`=1.
